bpm_beat_generator: RTL
=======================

Name: bpm_beat_generator

Overview:
Inverse of the audio-side BPM detector: takes a BPM value and produces a beat pulse train at that tempo, plus an audible click stream.
- The click stream is audio_sample/sample_valid at SAMPLE_RATE, the same sample format the detector consumes.
- Used as a metronome output to the audio codec path and as a loopback stimulus source for the detector.
- Period is computed as (60*CLOCK_FREQ)/bpm with a sequential divider; no combinational divide.

Parameters:
SAMPLE_WIDTH, 16, audio sample width (signed)
CLOCK_FREQ, 50_000_000, clk frequency in Hz
SAMPLE_RATE, 30_720, output sample rate in Hz
BPM_WIDTH, 16, width of bpm_in
MIN_BPM, 30, lowest accepted BPM
MAX_BPM, 300, highest accepted BPM
CLICK_SAMPLES, 614, click length in samples (~20 ms)
CLICK_AMPLITUDE, 8192, click square-wave amplitude
CLICK_HALF_PERIOD, 8, samples per click half-cycle (~1.92 kHz tone)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
bpm_in  input  BPM_WIDTH  requested tempo
bpm_load  input  1  one-cycle strobe; capture bpm_in
enable  input  1  beat/click generation enable
beat_pulse  output  1  one-cycle pulse per beat
downbeat  output  1  one-cycle pulse on bar downbeat (see Optional Feature)
audio_sample  output  SAMPLE_WIDTH  signed click audio
sample_valid  output  1  one-cycle strobe per sample
period_out  output  32  current beat period in clk cycles
busy  output  1  divider running
bpm_reject  output  1  one-cycle pulse: load refused

Behaviour:
- Reset values: all outputs 0; period_valid=0; NCO accumulator 0; FSM=IDLE.
- Load acceptance:
  - bpm_load in IDLE with MIN_BPM<=bpm_in<=MAX_BPM: capture bpm_in, FSM IDLE->DIV.
  - Out of range, or bpm_load while busy: bpm_reject=1 the next cycle; no state change.
- Divider:
  - FSM {IDLE, DIV}. busy=1 from the cycle after an accepted load for exactly 32 cycles.
  - Unsigned restoring division, 1 quotient bit per cycle. Numerator is the 32-bit constant 60*CLOCK_FREQ (3e9 fits unsigned).
  - On the final DIV cycle: period_out<=quotient, period_valid<=1, FSM->IDLE.
  - While in DIV, beats continue on the old period.
- Beat counter:
  - 32-bit count. Held at 0 while !enable or !period_valid.
  - Otherwise it increments. When count>=period_out-1: count<=0 and beat_pulse=1 for that cycle.
  - The first beat comes period_out cycles after enable rises.
  - A new, shorter period with count already past it gives a beat on the next cycle; no missed or double beats.
- Sample tick (NCO):
  - acc += SAMPLE_RATE every clk. If acc+SAMPLE_RATE>=CLOCK_FREQ, then acc<=acc+SAMPLE_RATE-CLOCK_FREQ and tick.
  - Exactly SAMPLE_RATE ticks per CLOCK_FREQ cycles.
  - sample_valid=tick. It runs regardless of enable.
- Click:
  - beat_pulse loads click_cnt=CLICK_SAMPLES and phase=0.
  - On each tick with click_cnt>0: audio_sample = +CLICK_AMPLITUDE for the first CLICK_HALF_PERIOD samples of each cycle, -CLICK_AMPLITUDE for the next; then click_cnt decrements.
  - On a tick with click_cnt==0, audio_sample=0.
  - audio_sample changes only on tick cycles and is held between them.
  - A beat during an active click restarts the click.
  - A beat and a tick in the same cycle: the tick emits the first click sample.
- enable falling: count<=0, click_cnt<=0. The next tick outputs 0.
- Reset mid-DIV: abort; period_valid=0; no beats until a new load completes.

Optional Feature:
BPM_GEN_ACCENT_EN
- Defined: a 2-bit beat index counts beats and is cleared when enable is low.
  - Beat index 0 asserts downbeat together with beat_pulse.
  - That beat's click uses 2*CLICK_AMPLITUDE, saturated to the signed max.
- Undefined: downbeat tied 0; all clicks use CLICK_AMPLITUDE.

Decomposition:
- Package bpm_pkg holds:
  - the divider FSM state enum;
  - DIV_WIDTH=32;
  - the function computing the 60*CLOCK_FREQ numerator (shared with the detector's BPM math).
- Sub-module bpm_seq_divider: 32-bit unsigned restoring divider.
  - Ports: clk, reset, start, dividend, divisor, quotient, done.
  - Latency: 32 cycles.

Test Plan:
- Load 120 at default params -> busy high 32 cycles; period_out=25_000_000; with enable=1, beat_pulse spacing exactly 25_000_000 cycles.
- Load 29, then 301 -> bpm_reject pulse each time; period_out and period_valid unchanged.
- Second bpm_load issued 5 cycles into DIV -> bpm_reject=1; first result completes unchanged.
- Run 50_000_000 cycles -> exactly 30_720 sample_valid pulses, never back-to-back.
- After a beat -> 614 ticks, first 8 at +8192, next 8 at -8192, alternating; then audio_sample=0 until the next beat.
- Assert reset during DIV with period previously valid -> all outputs 0; no beat_pulse afterwards until a new load completes.
- BPM_GEN_ACCENT_EN defined -> downbeat on beats 1, 5, 9; those clicks at ±16384.

Source files
------------

// File: rtl/bpm_pkg.sv
// rtl/bpm_pkg.sv - shared divider width, divider FSM state and BPM numerator helper
package bpm_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } div_state_e;

  // Clock cycles per minute; 60 * 50 MHz = 3e9 still fits an unsigned 32-bit word.
  function automatic logic [DIV_WIDTH-1:0] bpm_numerator(input longint unsigned clock_freq);
    longint unsigned prod;
    prod = 64'd60 * clock_freq;
    return prod[DIV_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/bpm_beat_generator_if.sv
// rtl/bpm_beat_generator_if.sv - tempo control, status and click stream of bpm_beat_generator
interface bpm_beat_generator_if
  import bpm_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BPM_WIDTH    = 16
);
  logic [BPM_WIDTH-1:0]           bpm_in;
  logic                           bpm_load;
  logic                           enable;
  logic                           beat_pulse;
  logic                           downbeat;
  logic signed [SAMPLE_WIDTH-1:0] audio_sample;
  logic                           sample_valid;
  logic [DIV_WIDTH-1:0]           period_out;
  logic                           busy;
  logic                           bpm_reject;

  modport master (
    output bpm_in, bpm_load, enable,
    input  beat_pulse, downbeat, audio_sample, sample_valid, period_out, busy, bpm_reject
  );

  modport slave (
    input  bpm_in, bpm_load, enable,
    output beat_pulse, downbeat, audio_sample, sample_valid, period_out, busy, bpm_reject
  );
endinterface

// File: rtl/bpm_seq_divider.sv
// rtl/bpm_seq_divider.sv - 32-bit unsigned restoring divider, one quotient bit per cycle
module bpm_seq_divider
  import bpm_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic                 done
);
  localparam int CNT_W = $clog2(DIV_WIDTH);

  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_WIDTH-1:0] quot_q, quot_d;
  logic [DIV_WIDTH-1:0] dsor_q, dsor_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic [DIV_WIDTH:0]   shifted;

  // One restoring step per cycle; done marks the step producing the last bit, whose
  // result is presented on quotient in that same cycle.
  always_comb begin
    rem_d   = rem_q;
    quot_d  = quot_q;
    dsor_d  = dsor_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    done    = 1'b0;
    shifted = {rem_q, quot_q[DIV_WIDTH-1]};
    if (start) begin
      rem_d  = '0;
      quot_d = dividend;
      dsor_d = divisor;
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      if (shifted >= {1'b0, dsor_q}) begin
        rem_d  = DIV_WIDTH'(shifted - {1'b0, dsor_q});
        quot_d = {quot_q[DIV_WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = shifted[DIV_WIDTH-1:0];
        quot_d = {quot_q[DIV_WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DIV_WIDTH - 1)) begin
        done  = 1'b1;
        run_d = 1'b0;
      end
    end
  end

  assign quotient = quot_d;

  // Divider state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsor_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dsor_q <= dsor_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end
endmodule

// File: rtl/bpm_beat_generator.sv
// rtl/bpm_beat_generator.sv - beat pulse train and click audio at a loaded BPM; BPM_GEN_ACCENT_EN accents bar downbeats
module bpm_beat_generator
  import bpm_pkg::*;
#(
  parameter int SAMPLE_WIDTH      = 16,
  parameter int CLOCK_FREQ        = 50_000_000,
  parameter int SAMPLE_RATE       = 30_720,
  parameter int BPM_WIDTH         = 16,
  parameter int MIN_BPM           = 30,
  parameter int MAX_BPM           = 300,
  parameter int CLICK_SAMPLES     = 614,
  parameter int CLICK_AMPLITUDE   = 8192,
  parameter int CLICK_HALF_PERIOD = 8
) (
  input logic                 clk,
  input logic                 reset,
  bpm_beat_generator_if.slave bus
);
  localparam logic [DIV_WIDTH-1:0] NUMERATOR = bpm_numerator(64'(CLOCK_FREQ));
  localparam int PH_W       = $clog2(2 * CLICK_HALF_PERIOD);
  localparam int CNT_W      = $clog2(CLICK_SAMPLES + 1);
  localparam int MAX_POS    = 2 ** (SAMPLE_WIDTH - 1) - 1;
  localparam int ACCENT_AMP = (2 * CLICK_AMPLITUDE > MAX_POS) ? MAX_POS : 2 * CLICK_AMPLITUDE;

  div_state_e                     state_q, state_d;
  logic [DIV_WIDTH-1:0]           period_q, period_d;
  logic                           period_valid_q, period_valid_d;
  logic                           reject_q, reject_d;
  logic [31:0]                    count_q, count_d;
  logic                           beat_q, beat_d;
  logic                           downbeat_q, downbeat_d;
  logic [1:0]                     beat_idx_q, beat_idx_d;
  logic                           accent_q, accent_d;
  logic [31:0]                    acc_q, acc_d, acc_sum;
  logic                           tick_q, tick_d;
  logic [CNT_W-1:0]               click_cnt_q, click_cnt_d;
  logic [PH_W-1:0]                phase_q, phase_d;
  logic signed [SAMPLE_WIDTH-1:0] audio_q, audio_d, amp;
  logic                           in_range, accept, div_done;
  logic [DIV_WIDTH-1:0]           div_quot;

  bpm_seq_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (accept),
    .dividend (NUMERATOR),
    .divisor  (DIV_WIDTH'(bus.bpm_in)),
    .quotient (div_quot),
    .done     (div_done)
  );

  // Load acceptance and the IDLE/DIV sequencing around the divider.
  always_comb begin
    in_range       = (32'(bus.bpm_in) >= 32'(MIN_BPM)) && (32'(bus.bpm_in) <= 32'(MAX_BPM));
    accept         = bus.bpm_load && (state_q == ST_IDLE) && in_range;
    reject_d       = bus.bpm_load && !accept;
    state_d        = state_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    if (accept) begin
      state_d = ST_DIV;
    end else if (div_done) begin
      state_d        = ST_IDLE;
      period_d       = div_quot;
      period_valid_d = 1'b1;
    end
  end

  // Beat counter; a period shorter than the running count fires on the next cycle.
  always_comb begin
    beat_d  = 1'b0;
    count_d = '0;
    if (bus.enable && period_valid_q) begin
      if (count_q >= period_q - 32'd1) beat_d = 1'b1;
      else count_d = count_q + 32'd1;
    end
`ifdef BPM_GEN_ACCENT_EN
    downbeat_d = beat_d && (beat_idx_q == 2'd0);
    beat_idx_d = !bus.enable ? 2'd0 : (beat_d ? beat_idx_q + 2'd1 : beat_idx_q);
`else
    downbeat_d = 1'b0;
    beat_idx_d = 2'd0;
`endif
  end

  // Sample-rate NCO and click synthesis; a beat and a tick together emit the first click sample.
  always_comb begin
    acc_sum     = acc_q + 32'(SAMPLE_RATE);
    tick_d      = acc_sum >= 32'(CLOCK_FREQ);
    acc_d       = tick_d ? acc_sum - 32'(CLOCK_FREQ) : acc_sum;
    click_cnt_d = click_cnt_q;
    phase_d     = phase_q;
    accent_d    = accent_q;
    audio_d     = audio_q;
    if (!bus.enable) click_cnt_d = '0;
    if (beat_d) begin
      click_cnt_d = CNT_W'(CLICK_SAMPLES);
      phase_d     = '0;
      accent_d    = downbeat_d;
    end
    amp = accent_d ? SAMPLE_WIDTH'(ACCENT_AMP) : SAMPLE_WIDTH'(CLICK_AMPLITUDE);
    if (tick_d) begin
      if (click_cnt_d != '0) begin
        audio_d     = (phase_d < PH_W'(CLICK_HALF_PERIOD)) ? amp : -amp;
        click_cnt_d = click_cnt_d - CNT_W'(1);
        phase_d     = (phase_d == PH_W'(2 * CLICK_HALF_PERIOD - 1)) ? '0 : phase_d + PH_W'(1);
      end else begin
        audio_d = '0;
      end
    end
  end

  // All state registers; reset aborts any division and invalidates the period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      reject_q       <= 1'b0;
      count_q        <= '0;
      beat_q         <= 1'b0;
      downbeat_q     <= 1'b0;
      beat_idx_q     <= '0;
      accent_q       <= 1'b0;
      acc_q          <= '0;
      tick_q         <= 1'b0;
      click_cnt_q    <= '0;
      phase_q        <= '0;
      audio_q        <= '0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      reject_q       <= reject_d;
      count_q        <= count_d;
      beat_q         <= beat_d;
      downbeat_q     <= downbeat_d;
      beat_idx_q     <= beat_idx_d;
      accent_q       <= accent_d;
      acc_q          <= acc_d;
      tick_q         <= tick_d;
      click_cnt_q    <= click_cnt_d;
      phase_q        <= phase_d;
      audio_q        <= audio_d;
    end
  end

  assign bus.beat_pulse   = beat_q;
  assign bus.downbeat     = downbeat_q;
  assign bus.audio_sample = audio_q;
  assign bus.sample_valid = tick_q;
  assign bus.period_out   = period_q;
  assign bus.busy         = (state_q == ST_DIV);
  assign bus.bpm_reject   = reject_q;
endmodule
